step_phase_sequencer: RTL and testbench

STEP_PHASE_SEQUENCER -- requirements
Module: step_phase_sequencer

---
 rtl/step_pkg.sv | 9 +
 rtl/step_idle_timer.sv | 19 +
 rtl/step_phase_sequencer.sv | 59 +++++
 tb/tb_step_phase_sequencer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// step_pkg: phase table, state encoding and shared constants for the step phase sequencer
package step_pkg;
  localparam int IDX_W = 3;
  localparam logic [23:0] IDLE_TIMEOUT_DEF = 24'd5_000_000;
  typedef enum logic {DEENERGIZED = 1'b0, ENERGIZED = 1'b1} state_t;
  localparam logic [7:0][3:0] PHASE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000
  };
endpackage

// File: rtl/step_idle_timer.sv
// step_idle_timer: counts running cycles and flags the last one before timeout (TIMEOUT=0 never expires)
module step_idle_timer
  import step_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  logic [23:0] count;
  assign expired = run && (TIMEOUT != '0) && (count == TIMEOUT - 24'd1);
  always_ff @(posedge clk) begin
    if (!rst || clear || expired) count <= '0;
    else if (run) count <= count + 24'd1;
  end
endmodule

// File: rtl/step_phase_sequencer.sv
// step_phase_sequencer: half/full step coil sequencer with signed position and idle de-energize
module step_phase_sequencer
  import step_pkg::*;
#(
  parameter logic [23:0] IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_in,
  input  logic             full_step,
  input  logic             dir,
  input  logic             enable,
  output logic [3:0]       coils,
  output logic             energized,
  output logic [POS_W-1:0] position
);
  state_t state;
  logic [IDX_W-1:0] idx, idx_n;
  logic [POS_W-1:0] pos_n;
  logic [1:0] mag;
  logic step_d, step_ev, run, expired;
  assign step_ev = step_in & ~step_d;
  assign mag = (full_step & idx[0]) ? 2'd2 : 2'd1;
  assign idx_n = dir ? idx + IDX_W'(mag) : idx - IDX_W'(mag);
  assign pos_n = dir ? position + POS_W'(mag) : position - POS_W'(mag);
  assign run = enable & (state == ENERGIZED);
  assign energized = state == ENERGIZED;
  step_idle_timer #(.TIMEOUT(IDLE_TIMEOUT)) u_timer (
    .clk,
    .rst,
    .clear(~run | step_ev),
    .run,
    .expired
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= DEENERGIZED;
      idx <= '0;
      position <= '0;
      coils <= 4'b0000;
      step_d <= 1'b1;
    end else begin
      step_d <= step_in;
      if (!enable) begin
        state <= DEENERGIZED;
        coils <= 4'b0000;
      end else if (step_ev) begin
        state <= ENERGIZED;
        idx <= idx_n;
        position <= pos_n;
        coils <= PHASE[idx_n];
      end else if (expired) begin
        state <= DEENERGIZED;
        coils <= 4'b0000;
      end
    end
  end
endmodule

// File: tb/tb_step_phase_sequencer.sv
// tb_step_phase_sequencer: directed vectors with hand-computed coil, state and position expectations
module tb_step_phase_sequencer;
  logic clk = 1'b0;
  logic rst, step_in, full_step, dir, enable;
  logic [3:0] coils;
  logic energized;
  logic [15:0] position;
  int vectors = 0;
  int errs = 0;
  always #5 clk = ~clk;
  step_phase_sequencer #(.IDLE_TIMEOUT(24'd10), .POS_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .step_in(step_in),
    .full_step(full_step),
    .dir(dir),
    .enable(enable),
    .coils(coils),
    .energized(energized),
    .position(position)
  );
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse();
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    tick();
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask
  logic [3:0] half_seq [8] = '{4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001, 4'b1000};
  logic [3:0] full_seq [3] = '{4'b1001, 4'b0011, 4'b0110};
  initial begin
    rst = 1'b0; step_in = 1'b0; full_step = 1'b0; dir = 1'b1; enable = 1'b1;
    tick(2);
    chk("reset_coils", 32'(coils), 32'h0);
    chk("reset_energized", 32'(energized), 32'h0);
    chk("reset_position", 32'(position), 32'h0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      pulse();
      chk($sformatf("half_fwd_%0d", i), 32'(coils), 32'(half_seq[i]));
    end
    chk("half_fwd_position", 32'(position), 32'd8);
    chk("half_fwd_energized", 32'(energized), 32'h1);
    do_reset();
    full_step = 1'b1; dir = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      pulse();
      chk($sformatf("full_rev_%0d", i), 32'(coils), 32'(full_seq[i]));
    end
    chk("full_rev_position", 32'(position), 32'h0000_FFFB);
    do_reset();
    full_step = 1'b0; dir = 1'b1;
    tick();
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    chk("timeout_first_step", 32'(coils), 32'b1100);
    tick(9);
    chk("timeout_still_on", 32'(energized), 32'h1);
    tick();
    chk("timeout_dropped", 32'(energized), 32'h0);
    chk("timeout_coils_off", 32'(coils), 32'h0);
    pulse();
    chk("resume_coils", 32'(coils), 32'b0100);
    chk("resume_position", 32'(position), 32'd2);
    tick(8);
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    chk("coincide_energized", 32'(energized), 32'h1);
    chk("coincide_coils", 32'(coils), 32'b0110);
    tick(9);
    chk("restart_still_on", 32'(energized), 32'h1);
    tick();
    chk("restart_dropped", 32'(energized), 32'h0);
    rst = 1'b0; step_in = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("held_high_no_step", 32'(coils), 32'h0);
    chk("held_high_position", 32'(position), 32'h0);
    step_in = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) pulse();
    chk("three_pulses_position", 32'(position), 32'd3);
    chk("three_pulses_coils", 32'(coils), 32'b0110);
    step_in = 1'b1;
    tick(4);
    step_in = 1'b0;
    tick();
    chk("long_high_one_step", 32'(position), 32'd4);
    step_in = 1'b1; enable = 1'b0;
    tick();
    chk("disable_coils_off", 32'(coils), 32'h0);
    chk("disable_energized", 32'(energized), 32'h0);
    chk("disable_position_frozen", 32'(position), 32'd4);
    step_in = 1'b0;
    tick();
    pulse();
    pulse();
    chk("disabled_pulses_ignored", 32'(position), 32'd4);
    enable = 1'b1;
    tick(3);
    chk("reenable_coils_off", 32'(coils), 32'h0);
    chk("reenable_energized", 32'(energized), 32'h0);
    pulse();
    chk("reenable_step_coils", 32'(coils), 32'b0011);
    chk("reenable_step_position", 32'(position), 32'd5);
    full_step = 1'b1; dir = 1'b0;
    tick(2);
    chk("mode_change_no_step", 32'(position), 32'd5);
    pulse();
    chk("full_from_odd_coils", 32'(coils), 32'b0110);
    chk("full_from_odd_position", 32'(position), 32'd3);
    step_in = 1'b1; rst = 1'b0;
    tick();
    chk("midrun_reset_coils", 32'(coils), 32'h0);
    chk("midrun_reset_position", 32'(position), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
